// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: IEEE 1149.1 TAP slave with TCK/TMS/TDI/TRST oversampled on clk_in.
// Define JTAG_USER_DR_EN to add the USER instruction (IR 5'h10) and its user data register.
module jtag_tap_responder #(
    parameter int          IR_WIDTH      = 5,
    parameter logic [31:0] IDCODE_VALUE  = 32'h1000_0DB3,
    parameter int          USER_DR_WIDTH = 32,
    parameter int          SYNC_STAGES   = 2
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     jtag_tck,
    input  logic                     jtag_tms,
    input  logic                     jtag_tdi,
    input  logic                     jtag_trst,
    output logic                     jtag_tdo,
    output logic                     jtag_tdo_oe,
    output logic [3:0]               tap_state,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    input  logic [USER_DR_WIDTH-1:0] user_dr_in,
    output logic                     user_dr_valid
);

`ifdef JTAG_USER_DR_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_EXIT2_DR = 4'h0, ST_EXIT1_DR = 4'h1, ST_SHIFT_DR = 4'h2, ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4, ST_UPD_DR   = 4'h5, ST_CAP_DR   = 4'h6, ST_SEL_DR   = 4'h7,
        ST_EXIT2_IR = 4'h8, ST_EXIT1_IR = 4'h9, ST_SHIFT_IR = 4'hA, ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC, ST_UPD_IR   = 4'hD, ST_CAP_IR   = 4'hE, ST_TLR      = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1'b1);
    localparam logic [IR_WIDTH-1:0] IR_USER    = {1'b1, {(IR_WIDTH-1){1'b0}}};
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic [3:0]               sync_r [SYNC_STAGES];
    logic                     tck_prev_r;
    logic                     tck_s, tms_s, tdi_s, trst_s;
    logic                     tck_rise_s, tck_fall_s;

    tap_state_e               state_r, state_next_s;
    dr_sel_e                  dr_sel_s;
    logic [IR_WIDTH-1:0]      ir_r, ir_sr_r;
    logic [31:0]              idcode_sr_r;
    logic                     bypass_r;
    logic [USER_DR_WIDTH-1:0] user_sr_r, user_dr_out_r;
    logic                     upd_pend_r, user_dr_valid_r;
    logic                     tdo_r, tdo_oe_r, tdo_next_s;

    // sync_r[0] packs {trst, tdi, tms, tck}; trst resets to its asserted level
    assign tck_s      = sync_r[SYNC_STAGES-1][0];
    assign tms_s      = sync_r[SYNC_STAGES-1][1];
    assign tdi_s      = sync_r[SYNC_STAGES-1][2];
    assign trst_s     = sync_r[SYNC_STAGES-1][3];
    assign tck_rise_s = tck_s & ~tck_prev_r;
    assign tck_fall_s = ~tck_s & tck_prev_r;

    // Input synchronizer chains and TCK edge history
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 4'b0000;
            end
            tck_prev_r <= 1'b0;
        end else begin
            sync_r[0] <= {jtag_trst, jtag_tdi, jtag_tms, jtag_tck};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            tck_prev_r <= tck_s;
        end
    end

    // TAP next-state function
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_TLR:      state_next_s = tms_s ? ST_TLR      : ST_RTI;
            ST_RTI:      state_next_s = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_next_s = tms_s ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_next_s = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_next_s = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_next_s = tms_s ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_next_s = tms_s ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_next_s = tms_s ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_next_s = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_next_s = tms_s ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_next_s = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_next_s = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_next_s = tms_s ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_next_s = tms_s ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_next_s = tms_s ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_next_s = tms_s ? ST_SEL_DR   : ST_RTI;
            default:     state_next_s = ST_TLR;
        endcase
    end

    // Instruction decode and TDO source selection
    always_comb begin
        dr_sel_s   = DR_BYPASS;
        tdo_next_s = 1'b0;
        if (ir_r == IR_IDCODE) begin
            dr_sel_s = DR_IDCODE;
        end else if (USER_EN && (ir_r == IR_USER)) begin
            dr_sel_s = DR_USER;
        end else begin
            dr_sel_s = DR_BYPASS;
        end
        if (state_r == ST_SHIFT_IR) begin
            tdo_next_s = ir_sr_r[0];
        end else begin
            case (dr_sel_s)
                DR_IDCODE: tdo_next_s = idcode_sr_r[0];
                DR_USER:   tdo_next_s = user_sr_r[0];
                default:   tdo_next_s = bypass_r;
            endcase
        end
    end

    // TAP state, IR/DR registers, TDO and the delayed user update pulse
    always_ff @(posedge clk_in) begin
        if (reset || !trst_s) begin
            state_r         <= ST_TLR;
            ir_r            <= IR_IDCODE;
            ir_sr_r         <= {IR_WIDTH{1'b0}};
            idcode_sr_r     <= IDCODE_VALUE;
            bypass_r        <= 1'b0;
            user_sr_r       <= {USER_DR_WIDTH{1'b0}};
            user_dr_out_r   <= {USER_DR_WIDTH{1'b0}};
            upd_pend_r      <= 1'b0;
            user_dr_valid_r <= 1'b0;
            tdo_r           <= 1'b0;
            tdo_oe_r        <= 1'b0;
        end else begin
            // Update lands one clk_in after the FSM enters Update-DR
            upd_pend_r      <= 1'b0;
            user_dr_valid_r <= upd_pend_r;
            if (upd_pend_r) begin
                user_dr_out_r <= user_sr_r;
            end
            if (tck_rise_s) begin
                state_r <= state_next_s;
                case (state_r)
                    ST_TLR:      ir_r    <= IR_IDCODE;
                    ST_CAP_IR:   ir_sr_r <= IR_CAPTURE;
                    ST_SHIFT_IR: ir_sr_r <= {tdi_s, ir_sr_r[IR_WIDTH-1:1]};
                    ST_UPD_IR:   ir_r    <= ir_sr_r;
                    ST_CAP_DR: begin
                        case (dr_sel_s)
                            DR_IDCODE: idcode_sr_r <= IDCODE_VALUE;
                            DR_USER:   user_sr_r   <= user_dr_in;
                            default:   bypass_r    <= 1'b0;
                        endcase
                    end
                    ST_SHIFT_DR: begin
                        case (dr_sel_s)
                            DR_IDCODE: idcode_sr_r <= {tdi_s, idcode_sr_r[31:1]};
                            DR_USER:   user_sr_r   <= {tdi_s, user_sr_r[USER_DR_WIDTH-1:1]};
                            default:   bypass_r    <= tdi_s;
                        endcase
                    end
                    ST_EXIT1_DR, ST_EXIT2_DR: upd_pend_r <= tms_s && (dr_sel_s == DR_USER);
                    default: ;
                endcase
            end else if (tck_fall_s) begin
                if ((state_r == ST_SHIFT_DR) || (state_r == ST_SHIFT_IR)) begin
                    tdo_r    <= tdo_next_s;
                    tdo_oe_r <= 1'b1;
                end else begin
                    tdo_oe_r <= 1'b0;
                end
            end
        end
    end

    assign jtag_tdo      = tdo_r;
    assign jtag_tdo_oe   = tdo_oe_r;
    assign tap_state     = state_r;
    assign user_dr_out   = USER_EN ? user_dr_out_r : {USER_DR_WIDTH{1'b0}};
    assign user_dr_valid = USER_EN & user_dr_valid_r;

endmodule
